id_stage: RTL and testbench

//  Registered LA32R decode stage between the IF/ID boundary and EX. It decodes a
//  12-instruction integer subset, reads the regfile and forwards results from EX/MEM.
//  It stalls on load-use hazards and exchanges valid/ready handshakes with both neighbours.

---
 rtl/id_stage_pkg.sv | 57 +++++
 rtl/id_stage_decoder.sv | 88 ++++++++
 rtl/id_stage.sv | 154 +++++++++++++++
 tb/tb_id_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared constants for the LA32R decode stage: ALU op/result-class codes,
// opcode field values for the supported integer subset, immediate helper.
package id_stage_pkg;

    // ALU operation codes carried to EX
    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_ADD = 8'h01;
    localparam logic [7:0] ALU_SUB = 8'h02;
    localparam logic [7:0] ALU_SLT = 8'h03;
    localparam logic [7:0] ALU_AND = 8'h04;
    localparam logic [7:0] ALU_OR  = 8'h05;
    localparam logic [7:0] ALU_XOR = 8'h06;
    localparam logic [7:0] ALU_NOR = 8'h07;
    localparam logic [7:0] ALU_LUI = 8'h08;

    // Result class selected in EX
    localparam logic [2:0] ALU_SEL_NOP   = 3'd0;
    localparam logic [2:0] ALU_SEL_LOGIC = 3'd1;
    localparam logic [2:0] ALU_SEL_ARITH = 3'd2;
    localparam logic [2:0] ALU_SEL_MOVE  = 3'd3;

    // 3R-type: opcode in inst[31:15]
    localparam logic [16:0] OP17_ADD_W = 17'h00020;
    localparam logic [16:0] OP17_SUB_W = 17'h00022;
    localparam logic [16:0] OP17_SLT   = 17'h00024;
    localparam logic [16:0] OP17_NOR   = 17'h00028;
    localparam logic [16:0] OP17_AND   = 17'h00029;
    localparam logic [16:0] OP17_OR    = 17'h0002A;
    localparam logic [16:0] OP17_XOR   = 17'h0002B;

    // 2RI12-type: opcode in inst[31:22]
    localparam logic [9:0] OP10_ADDI_W = 10'h00A;
    localparam logic [9:0] OP10_ANDI   = 10'h00D;
    localparam logic [9:0] OP10_ORI    = 10'h00E;
    localparam logic [9:0] OP10_XORI   = 10'h00F;

    // 1RI20-type: opcode in inst[31:25]
    localparam logic [6:0] OP7_LU12I_W = 7'h0A;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_UI12,
        IMM_SI12,
        IMM_SI20
    } imm_kind_e;

    // f is inst[24:5]; the 12-bit immediate field inst[21:10] sits at f[16:5]
    function automatic logic [31:0] gen_imm(input imm_kind_e kind, input logic [19:0] f);
        case (kind)
            IMM_UI12: return {20'b0, f[16:5]};
            IMM_SI12: return {{20{f[16]}}, f[16:5]};
            IMM_SI20: return {f, 12'b0};
            default:  return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_decoder.sv
// Combinational instruction decoder: opcode match, ALU op, register read
// addresses (zero when a source is unused), immediate and destination.
module id_stage_decoder
    import id_stage_pkg::*;
#(
    parameter int RADDR_W = 5
) (
    input  logic [31:0]        inst_i,
    output logic [7:0]         aluop_o,
    output logic [2:0]         alusel_o,
    output logic [RADDR_W-1:0] raddr1_o,
    output logic [RADDR_W-1:0] raddr2_o,
    output logic               use_imm_o,
    output logic [31:0]        imm_o,
    output logic [RADDR_W-1:0] waddr_o,
    output logic               wen_o,
    output logic               illegal_o
);

    logic [16:0]  op17;
    logic [9:0]   op10;
    logic [6:0]   op7;
    logic [4:0]   rd, rj, rk;
    logic         re1, re2, legal;
    imm_kind_e    kind;

    assign op17 = inst_i[31:15];
    assign op10 = inst_i[31:22];
    assign op7  = inst_i[31:25];
    assign rd   = inst_i[4:0];
    assign rj   = inst_i[9:5];
    assign rk   = inst_i[14:10];

    // Opcode match; 3R opcodes have inst[31:22]==0 so the two tables never overlap
    always_comb begin
        aluop_o   = ALU_NOP;
        alusel_o  = ALU_SEL_NOP;
        re1       = 1'b0;
        re2       = 1'b0;
        use_imm_o = 1'b0;
        kind      = IMM_NONE;
        legal     = 1'b0;
        if (op7 == OP7_LU12I_W) begin
            aluop_o   = ALU_LUI;
            alusel_o  = ALU_SEL_MOVE;
            use_imm_o = 1'b1;
            kind      = IMM_SI20;
            legal     = 1'b1;
        end else begin
            case (op10)
                OP10_ADDI_W: begin aluop_o = ALU_ADD; alusel_o = ALU_SEL_ARITH; kind = IMM_SI12; legal = 1'b1; end
                OP10_ANDI:   begin aluop_o = ALU_AND; alusel_o = ALU_SEL_LOGIC; kind = IMM_UI12; legal = 1'b1; end
                OP10_ORI:    begin aluop_o = ALU_OR;  alusel_o = ALU_SEL_LOGIC; kind = IMM_UI12; legal = 1'b1; end
                OP10_XORI:   begin aluop_o = ALU_XOR; alusel_o = ALU_SEL_LOGIC; kind = IMM_UI12; legal = 1'b1; end
                default: ;
            endcase
            if (legal) begin
                re1       = 1'b1;
                use_imm_o = 1'b1;
            end
            case (op17)
                OP17_ADD_W: begin aluop_o = ALU_ADD; alusel_o = ALU_SEL_ARITH; legal = 1'b1; end
                OP17_SUB_W: begin aluop_o = ALU_SUB; alusel_o = ALU_SEL_ARITH; legal = 1'b1; end
                OP17_SLT:   begin aluop_o = ALU_SLT; alusel_o = ALU_SEL_ARITH; legal = 1'b1; end
                OP17_NOR:   begin aluop_o = ALU_NOR; alusel_o = ALU_SEL_LOGIC; legal = 1'b1; end
                OP17_AND:   begin aluop_o = ALU_AND; alusel_o = ALU_SEL_LOGIC; legal = 1'b1; end
                OP17_OR:    begin aluop_o = ALU_OR;  alusel_o = ALU_SEL_LOGIC; legal = 1'b1; end
                OP17_XOR:   begin aluop_o = ALU_XOR; alusel_o = ALU_SEL_LOGIC; legal = 1'b1; end
                default: ;
            endcase
            if (op10 == 10'h000 && legal) begin
                re1 = 1'b1;
                re2 = 1'b1;
            end
        end
    end

    // Unused sources read r0 so they can never match a bypass or hazard
    always_comb begin
        raddr1_o  = re1 ? RADDR_W'(rj) : '0;
        raddr2_o  = re2 ? RADDR_W'(rk) : '0;
        illegal_o = !legal;
        waddr_o   = legal ? RADDR_W'(rd) : '0;
        wen_o     = legal && (rd != 5'd0);
        imm_o     = gen_imm(kind, inst_i[24:5]);
    end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: decodes, reads the regfile, bypasses EX/MEM
// results, stalls on load-use, and handshakes with IF and EX.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int FWD_EN  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_inst,
    output logic [RADDR_W-1:0] rf_raddr1,
    output logic [RADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    input  logic               ex_wen,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic               ex_is_load,
    input  logic               mem_wen,
    input  logic [RADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0]  mem_wdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [7:0]         out_aluop,
    output logic [2:0]         out_alusel,
    output logic [DATA_W-1:0]  out_src1,
    output logic [DATA_W-1:0]  out_src2,
    output logic [RADDR_W-1:0] out_waddr,
    output logic               out_wen,
    output logic               out_illegal
);

    logic [7:0]         dec_aluop;
    logic [2:0]         dec_alusel;
    logic [RADDR_W-1:0] dec_raddr1, dec_raddr2, dec_waddr;
    logic               dec_use_imm, dec_wen, dec_illegal;
    logic [31:0]        dec_imm;

    logic               ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic               hazard, in_fire, load;
    logic [DATA_W-1:0]  src1_d, src2_d;

    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_pc_q;
    logic [7:0]         out_aluop_q;
    logic [2:0]         out_alusel_q;
    logic [DATA_W-1:0]  out_src1_q, out_src2_q;
    logic [RADDR_W-1:0] out_waddr_q;
    logic               out_wen_q, out_illegal_q;

    id_stage_decoder #(.RADDR_W(RADDR_W)) u_id_decoder (
        .inst_i    (in_inst),
        .aluop_o   (dec_aluop),
        .alusel_o  (dec_alusel),
        .raddr1_o  (dec_raddr1),
        .raddr2_o  (dec_raddr2),
        .use_imm_o (dec_use_imm),
        .imm_o     (dec_imm),
        .waddr_o   (dec_waddr),
        .wen_o     (dec_wen),
        .illegal_o (dec_illegal)
    );

    assign rf_raddr1 = dec_raddr1;
    assign rf_raddr2 = dec_raddr2;

    // Bypass matches; a zero read address means "r0 or unused", never a match
    always_comb begin
        ex_hit1  = ex_wen  && (ex_waddr  == dec_raddr1) && (dec_raddr1 != '0);
        ex_hit2  = ex_wen  && (ex_waddr  == dec_raddr2) && (dec_raddr2 != '0);
        mem_hit1 = mem_wen && (mem_waddr == dec_raddr1) && (dec_raddr1 != '0);
        mem_hit2 = mem_wen && (mem_waddr == dec_raddr2) && (dec_raddr2 != '0);
    end

    // Load-use stalls when forwarding; without forwarding any pending write stalls
    always_comb begin
        if (FWD_EN != 0) hazard = ex_is_load && (ex_hit1 || ex_hit2);
        else             hazard = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
        in_ready = !rst && !hazard && (!out_valid_q || out_ready);
        in_fire  = in_valid && in_ready;
    end

    // Operand select: r0 -> 0, then EX, then MEM, then regfile; imm replaces src2
    always_comb begin
        if (dec_raddr1 == '0) src1_d = '0;
        else if (ex_hit1)     src1_d = ex_wdata;
        else if (mem_hit1)    src1_d = mem_wdata;
        else                  src1_d = rf_rdata1;
        if (dec_use_imm)      src2_d = DATA_W'(dec_imm);
        else if (dec_raddr2 == '0) src2_d = '0;
        else if (ex_hit2)     src2_d = ex_wdata;
        else if (mem_hit2)    src2_d = mem_wdata;
        else                  src2_d = rf_rdata2;
    end

    // Valid next-state: flush wins, then a new accept, then drain (bubble) on out_ready
    always_comb begin
        out_valid_d = out_valid_q;
        load        = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
            load        = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output bundle register; payload only changes on an accepted instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_aluop_q   <= '0;
            out_alusel_q  <= '0;
            out_src1_q    <= '0;
            out_src2_q    <= '0;
            out_waddr_q   <= '0;
            out_wen_q     <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                out_pc_q      <= in_pc;
                out_aluop_q   <= dec_aluop;
                out_alusel_q  <= dec_alusel;
                out_src1_q    <= src1_d;
                out_src2_q    <= src2_d;
                out_waddr_q   <= dec_waddr;
                out_wen_q     <= dec_wen;
                out_illegal_q <= dec_illegal;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_aluop   = out_aluop_q;
    assign out_alusel  = out_alusel_q;
    assign out_src1    = out_src1_q;
    assign out_src2    = out_src2_q;
    assign out_waddr   = out_waddr_q;
    assign out_wen     = out_wen_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random traffic, checked by a
// scoreboard fed from a mnemonic-level reference model.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_inst;
    logic [4:0]  rf_raddr1, rf_raddr2, ex_waddr, mem_waddr, out_waddr;
    logic [31:0] rf_rdata1, rf_rdata2, ex_wdata, mem_wdata, out_pc, out_src1, out_src2;
    logic        ex_wen, ex_is_load, mem_wen, out_wen, out_illegal;
    logic [7:0]  out_aluop;
    logic [2:0]  out_alusel;

    logic [31:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    id_stage #(.DATA_W(32), .RADDR_W(5), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_aluop(out_aluop), .out_alusel(out_alusel), .out_src1(out_src1), .out_src2(out_src2),
        .out_waddr(out_waddr), .out_wen(out_wen), .out_illegal(out_illegal)
    );

    int total = 0;
    int bad   = 0;

    typedef enum int {M_ADD, M_SUB, M_SLT, M_AND, M_OR, M_XOR, M_NOR,
                      M_ADDI, M_ANDI, M_ORI, M_XORI, M_LU12I, M_BAD} mn_e;

    localparam logic [31:0] BASE [12] = '{32'h00100000, 32'h00110000, 32'h00120000,
        32'h00148000, 32'h00150000, 32'h00158000, 32'h00140000,
        32'h02800000, 32'h03400000, 32'h03800000, 32'h03C00000, 32'h14000000};

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  wa;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t q[$];
    logic exp_ov = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic mn_e classify(input logic [31:0] i);
        for (int k = 0; k < 7; k++)  if ((i & 32'hFFFF8000) == BASE[k]) return mn_e'(k);
        for (int k = 7; k < 11; k++) if ((i & 32'hFFC00000) == BASE[k]) return mn_e'(k);
        if ((i & 32'hFE000000) == BASE[11]) return M_LU12I;
        return M_BAD;
    endfunction

    // Register value seen by an instruction in ID: EX result, else MEM, else regfile
    function automatic logic [31:0] opnd(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (ex_wen && ex_waddr == r) return ex_wdata;
        if (mem_wen && mem_waddr == r) return mem_wdata;
        return rf[r];
    endfunction

    function automatic int nsrc(input mn_e m);
        if (m <= M_NOR) return 2;
        if (m <= M_XORI) return 1;
        return 0;
    endfunction

    function automatic logic hazard_of(input logic [31:0] i);
        mn_e m = classify(i);
        logic [4:0] rj = 5'((i >> 5) & 32'h1F);
        logic [4:0] rk = 5'((i >> 10) & 32'h1F);
        if (!(ex_wen && ex_is_load) || ex_waddr == 0) return 1'b0;
        if (nsrc(m) >= 1 && ex_waddr == rj) return 1'b1;
        if (nsrc(m) == 2 && ex_waddr == rk) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        mn_e m = classify(i);
        logic [4:0]  rd = 5'(i & 32'h1F);
        logic [4:0]  rj = 5'((i >> 5) & 32'h1F);
        logic [4:0]  rk = 5'((i >> 10) & 32'h1F);
        logic [31:0] u12 = (i >> 10) & 32'hFFF;
        logic [31:0] s12 = (u12 >= 32'd2048) ? u12 - 32'd4096 : u12;
        logic [31:0] hi  = ((i >> 5) & 32'hFFFFF) << 12;
        e = '0;
        e.pc = pc;
        case (m)
            M_ADD, M_ADDI:  begin e.aluop = ALU_ADD; e.alusel = ALU_SEL_ARITH; end
            M_SUB:          begin e.aluop = ALU_SUB; e.alusel = ALU_SEL_ARITH; end
            M_SLT:          begin e.aluop = ALU_SLT; e.alusel = ALU_SEL_ARITH; end
            M_AND, M_ANDI:  begin e.aluop = ALU_AND; e.alusel = ALU_SEL_LOGIC; end
            M_OR,  M_ORI:   begin e.aluop = ALU_OR;  e.alusel = ALU_SEL_LOGIC; end
            M_XOR, M_XORI:  begin e.aluop = ALU_XOR; e.alusel = ALU_SEL_LOGIC; end
            M_NOR:          begin e.aluop = ALU_NOR; e.alusel = ALU_SEL_LOGIC; end
            M_LU12I:        begin e.aluop = ALU_LUI; e.alusel = ALU_SEL_MOVE;  end
            default:        begin e.aluop = ALU_NOP; e.alusel = ALU_SEL_NOP;   end
        endcase
        if (nsrc(m) == 2) begin e.s1 = opnd(rj); e.s2 = opnd(rk); end
        else if (m == M_ADDI) begin e.s1 = opnd(rj); e.s2 = s12; end
        else if (nsrc(m) == 1) begin e.s1 = opnd(rj); e.s2 = u12; end
        else if (m == M_LU12I) e.s2 = hi;
        e.ill = (m == M_BAD);
        e.wa  = e.ill ? 5'd0 : rd;
        e.wen = !e.ill && rd != 0;
        return e;
    endfunction

    // Reference model: checks in_ready and predicts what enters the output register
    always @(negedge clk) begin
        logic rdy;
        #2;
        rdy = !rst && !hazard_of(in_inst) && (!exp_ov || out_ready);
        chk("in_ready", in_ready, rdy);
        if (rst || flush) begin
            q.delete();
            exp_ov = 1'b0;
        end else if (in_valid && rdy) begin
            q.push_back(model(in_inst, in_pc));
            exp_ov = 1'b1;
        end else if (out_ready) begin
            exp_ov = 1'b0;
        end
    end

    // Monitor: out_valid against the model, bundles popped on each EX handshake
    always @(negedge clk) begin
        exp_t e, a;
        chk("out_valid", out_valid, exp_ov);
        if (out_valid && out_ready) begin
            a = '{out_pc, out_aluop, out_alusel, out_src1, out_src2, out_waddr, out_wen, out_illegal};
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL bundle unexpected pc=%0h", out_pc);
            end else begin
                e = q.pop_front();
                chk("bundle", a, e);
            end
        end
    end

    function automatic logic [31:0] enc_r(input int k, input int rd, input int rj, input int rk);
        return BASE[k] | (32'(rk) << 10) | (32'(rj) << 5) | 32'(rd);
    endfunction
    function automatic logic [31:0] enc_i(input int k, input int rd, input int rj, input logic [31:0] imm);
        return BASE[k] | ((imm & 32'hFFF) << 10) | (32'(rj) << 5) | 32'(rd);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        rst = 1; flush = 0; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 1;
        ex_wen = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wen = 0; mem_waddr = 0; mem_wdata = 0;
        rf[0] = 0;
        for (int r = 1; r < 32; r++) rf[r] = $urandom;
        tick(); tick(); #3;
        chk("rst in_ready", in_ready, 0);
        chk("rst outs", {out_valid, out_pc, out_aluop, out_alusel, out_src1, out_src2, out_waddr, out_wen, out_illegal}, 0);
        rst = 0;
        tick();
        chk("in_ready after rst", in_ready, 1);

        // ori r1,r0,0x5A5
        in_valid = 1; in_pc = 32'h1000; in_inst = enc_i(9, 1, 0, 32'h5A5);
        tick(); #3;
        chk("ori", {out_valid, out_src1, out_src2, out_waddr, out_wen, out_aluop},
            {1'b1, 32'd0, 32'h5A5, 5'd1, 1'b1, ALU_OR});

        // addi.w r2,r3,-1 with EX and MEM both writing r3
        rf[3] = 7; ex_wen = 1; ex_waddr = 3; ex_wdata = 32'h10;
        mem_wen = 1; mem_waddr = 3; mem_wdata = 32'h20;
        in_pc = 32'h1004; in_inst = enc_i(7, 2, 3, 32'hFFF);
        tick(); #3;
        chk("addi fwd", {out_src1, out_src2, out_aluop}, {32'h10, 32'hFFFFFFFF, ALU_ADD});

        // add.w r4,r5,r6 behind a load to r5
        ex_wen = 1; ex_is_load = 1; ex_waddr = 5; ex_wdata = 32'hDEAD;
        mem_wen = 1; mem_waddr = 5; mem_wdata = 32'h55;
        in_pc = 32'h1008; in_inst = enc_r(0, 4, 5, 6);
        #1; chk("load-use stall", in_ready, 0);
        tick(); #3;
        chk("bubble", {out_valid, in_ready}, {1'b0, 1'b0});
        ex_wen = 0; ex_is_load = 0;
        #1; chk("stall release", in_ready, 1);
        tick(); #3;
        chk("add after load", {out_valid, out_pc, out_src1, out_src2}, {1'b1, 32'h1008, 32'h55, rf[6]});

        // EX back-pressure for 3 cycles
        mem_wen = 0;
        in_pc = 32'h100C; in_inst = enc_r(5, 7, 1, 2);
        tick(); #3;
        out_ready = 0; in_pc = 32'h1010; in_inst = enc_r(4, 8, 1, 2);
        #1; chk("backpressure in_ready", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick(); #3;
            chk("hold", {out_valid, out_pc, in_ready}, {1'b1, 32'h100C, 1'b0});
        end
        out_ready = 1;
        tick(); #3;
        chk("after hold", out_pc, 32'h1010);

        // flush in the same cycle as a handshake
        flush = 1; in_pc = 32'h1014; in_inst = enc_i(9, 9, 1, 32'h0F0);
        tick(); flush = 0; #3;
        chk("flush drop", out_valid, 0);
        in_pc = 32'h1018; in_inst = enc_i(8, 10, 1, 32'h0F0);
        tick(); #3;
        chk("after flush", {out_valid, out_pc}, {1'b1, 32'h1018});

        // illegal word, write to r0, reset during a stall
        in_pc = 32'h101C; in_inst = 32'hFFFFFFFF;
        tick(); #3;
        chk("illegal", {out_illegal, out_wen, out_aluop}, {1'b1, 1'b0, ALU_NOP});
        in_pc = 32'h1020; in_inst = enc_r(4, 0, 1, 2);
        tick(); #3;
        chk("rd r0", {out_wen, out_illegal}, {1'b0, 1'b0});
        out_ready = 0; in_pc = 32'h1024; in_inst = enc_r(0, 11, 1, 2);
        tick(); #3;
        chk("stalled", {out_valid, out_pc}, {1'b1, 32'h1020});
        rst = 1;
        tick(); #3;
        chk("rst mid-stall", {in_ready, out_valid, out_pc, out_aluop, out_alusel, out_src1, out_src2, out_waddr, out_wen, out_illegal}, 0);
        rst = 0; in_valid = 0; out_ready = 1;
        tick();

        // random traffic
        repeat (3000) begin
            tick();
            in_valid = $urandom_range(0, 3) != 0;
            in_pc    = $urandom & 32'hFFFFFFFC;
            k = $urandom_range(0, 12);
            if (k < 7)       in_inst = enc_r(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            else if (k < 12) in_inst = enc_i(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            else             in_inst = $urandom;
            if (k == 11) in_inst = BASE[11] | (($urandom & 32'hFFFFF) << 5) | 32'($urandom_range(0, 7));
            ex_wen = $urandom_range(0, 1); ex_waddr = 5'($urandom_range(0, 7));
            ex_wdata = $urandom; ex_is_load = $urandom_range(0, 3) == 0;
            mem_wen = $urandom_range(0, 1); mem_waddr = 5'($urandom_range(0, 7));
            mem_wdata = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 19) == 0;
            rst = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 31)] = $urandom;
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1; ex_wen = 0; mem_wen = 0;
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
